// File: rtl/lsu_maint_pkg.sv
// Shared types for the LSU cache-maintenance issue stage: op and state
// encodings plus the operation-select decode helpers.
package lsu_maint_pkg;

  typedef enum logic [1:0] {
    OP_WB    = 2'd0,
    OP_INVAL = 2'd1,
    OP_FLUSH = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // sel is packed {wb, inval, flush}
  function automatic logic sel_onehot(input logic [2:0] sel);
    return (sel == 3'b100) || (sel == 3'b010) || (sel == 3'b001);
  endfunction

  function automatic op_e sel_to_op(input logic [2:0] sel);
    if (sel[2])      return OP_WB;
    else if (sel[1]) return OP_INVAL;
    else             return OP_FLUSH;
  endfunction

endpackage

// File: rtl/lsu_outstanding_ctr.sv
// Saturating up/down counter of cache operations accepted but not yet acked.
// A decrement at zero is dropped and reported on underflow instead.
module lsu_outstanding_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       underflow
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic inc_eff;
  logic dec_eff;

  assign dec_eff   = dec & (count != 4'd0);
  assign inc_eff   = inc & ((count != MAX_C) | dec_eff);
  assign underflow = dec & ~inc & (count == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (inc_eff & ~dec_eff) begin
      count <= count + 4'd1;
    end else if (dec_eff & ~inc_eff) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/lsu_mem_maint_issue.sv
// Issue stage for LSU cache-maintenance ops: captures a guarded request,
// holds it on the cache port until accepted and tracks outstanding acks.
//
// state    | meaning
// ST_IDLE  | no op held; may capture when below the outstanding limit
// ST_PEND  | op presented on mem_*, held stable until mem_accept_i
// ST_DRAIN | flush captured, waiting for outstanding count to reach 0
module lsu_mem_maint_issue
  import lsu_maint_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              opcode_valid_i,
  input  logic              req_wb_i,
  input  logic              req_inval_i,
  input  logic              req_flush_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_writeback_o,
  output logic              mem_invalidate_o,
  output logic              mem_flush_o,
  input  logic              mem_accept_i,
  input  logic              mem_ack_i,
  input  logic              mem_error_i,
  output logic              resp_valid_o,
  output logic              resp_error_o,
  output logic [3:0]        outstanding_o,
  output logic              sel_err_o,
  output logic              proto_err_o
);

  localparam logic [3:0] MAX_C = 4'(MAX_OUTSTANDING);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_d;
  logic [2:0]        sel;
  logic [2:0]        strobe_d;
  logic              capture;
  logic              fire;
  logic              sel_err_d;
  logic              underflow;
  logic [3:0]        count;

  assign sel         = {req_wb_i, req_inval_i, req_flush_i};
  assign req_ready_o = (state_q == ST_IDLE) & (count < MAX_C);
  assign capture     = req_valid_i & opcode_valid_i & req_ready_o;
  assign fire        = (state_q == ST_PEND) & mem_accept_i;

  lsu_outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_ctr (
    .clk       (clk),
    .rst       (rst_i),
    .inc       (fire),
    .dec       (mem_ack_i),
    .count     (count),
    .underflow (underflow)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = mem_addr_o;
    sel_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          if (!sel_onehot(sel)) begin
            sel_err_d = 1'b1;
          end else begin
            op_d    = sel_to_op(sel);
            addr_d  = req_addr_i;
            state_d = ((op_d == OP_FLUSH) && (count != 4'd0)) ? ST_DRAIN : ST_PEND;
          end
        end
      end
      ST_PEND:  if (mem_accept_i)    state_d = ST_IDLE;
      ST_DRAIN: if (count == 4'd0)   state_d = ST_PEND;
      default:                       state_d = ST_IDLE;
    endcase
    // strobes are registered copies of the op that will be presented next cycle
    strobe_d = (state_d == ST_PEND) ?
               {op_d == OP_WB, op_d == OP_INVAL, op_d == OP_FLUSH} : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      op_q             <= OP_WB;
      mem_addr_o       <= '0;
      mem_writeback_o  <= 1'b0;
      mem_invalidate_o <= 1'b0;
      mem_flush_o      <= 1'b0;
      resp_valid_o     <= 1'b0;
      resp_error_o     <= 1'b0;
      sel_err_o        <= 1'b0;
      proto_err_o      <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      mem_addr_o       <= addr_d;
      mem_writeback_o  <= strobe_d[2];
      mem_invalidate_o <= strobe_d[1];
      mem_flush_o      <= strobe_d[0];
      resp_valid_o     <= mem_ack_i;
      resp_error_o     <= mem_error_i;
      sel_err_o        <= sel_err_d;
      proto_err_o      <= proto_err_o | underflow;
    end
  end

  assign outstanding_o = count;

endmodule

// File: tb/tb_lsu_mem_maint_issue.sv
// Self-checking bench for lsu_mem_maint_issue: issued ops and responses are
// scoreboarded through queues, state-level expectations checked directly.
module tb_lsu_mem_maint_issue;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, opcode_valid_i;
  logic        req_wb_i, req_inval_i, req_flush_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o;
  logic [31:0] mem_addr_o;
  logic        mem_writeback_o, mem_invalidate_o, mem_flush_o;
  logic        mem_accept_i, mem_ack_i, mem_error_i;
  logic        resp_valid_o, resp_error_o;
  logic [3:0]  outstanding_o;
  logic        sel_err_o, proto_err_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [34:0] issue_q[$];   // {wb, inval, flush, addr}
  logic        resp_q[$];

  always #5 clk = ~clk;

  lsu_mem_maint_issue #(.MAX_OUTSTANDING(4), .ADDR_W(32)) dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .opcode_valid_i   (opcode_valid_i),
    .req_wb_i         (req_wb_i),
    .req_inval_i      (req_inval_i),
    .req_flush_i      (req_flush_i),
    .req_addr_i       (req_addr_i),
    .req_ready_o      (req_ready_o),
    .mem_addr_o       (mem_addr_o),
    .mem_writeback_o  (mem_writeback_o),
    .mem_invalidate_o (mem_invalidate_o),
    .mem_flush_o      (mem_flush_o),
    .mem_accept_i     (mem_accept_i),
    .mem_ack_i        (mem_ack_i),
    .mem_error_i      (mem_error_i),
    .resp_valid_o     (resp_valid_o),
    .resp_error_o     (resp_error_o),
    .outstanding_o    (outstanding_o),
    .sel_err_o        (sel_err_o),
    .proto_err_o      (proto_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic g, input logic [2:0] sel, input logic [31:0] a);
    req_valid_i    = v;
    opcode_valid_i = g;
    {req_wb_i, req_inval_i, req_flush_i} = sel;
    req_addr_i     = a;
  endtask

  // capture then let it be accepted; accept is held high here
  task automatic issue_op(input logic [2:0] sel, input logic [31:0] a);
    issue_q.push_back({sel, a});
    mem_accept_i = 1'b1;
    set_req(1'b1, 1'b1, sel, a);
    step();
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    step();
  endtask

  task automatic do_ack(input logic err);
    resp_q.push_back(err);
    mem_ack_i   = 1'b1;
    mem_error_i = err;
    step();
    mem_ack_i   = 1'b0;
    mem_error_i = 1'b0;
  endtask

  // monitor: a presented op with accept high is an issue; resp pulses pop responses
  always @(negedge clk) begin
    if (!rst_i) begin
      if ((mem_writeback_o | mem_invalidate_o | mem_flush_o) & mem_accept_i) begin
        if (issue_q.size() == 0)
          chk("issue_extra", {61'd0, mem_writeback_o, mem_invalidate_o, mem_flush_o}, 64'd0);
        else
          chk("issue", {29'd0, mem_writeback_o, mem_invalidate_o, mem_flush_o, mem_addr_o},
              {29'd0, issue_q.pop_front()});
      end
      if (resp_valid_o) begin
        if (resp_q.size() == 0)
          chk("resp_extra", 64'(resp_valid_o), 64'd0);
        else
          chk("resp_error", 64'(resp_error_o), 64'(resp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_error_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    step();
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_strobes", {61'd0, mem_writeback_o, mem_invalidate_o, mem_flush_o}, 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_count", 64'(outstanding_o), 64'd0);
    chk("rst_flags", {60'd0, resp_valid_o, resp_error_o, sel_err_o, proto_err_o}, 64'd0);

    // guard low: request ignored entirely
    set_req(1'b1, 1'b0, 3'b100, 32'hdead);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("guard", {58'd0, mem_writeback_o, mem_invalidate_o, mem_flush_o, sel_err_o, outstanding_o == 4'd0, req_ready_o},
          64'b000011);
    end
    set_req(1'b0, 1'b0, 3'b000, 32'h0);

    // basic writeback with accept held
    issue_q.push_back({3'b100, 32'h1000});
    mem_accept_i = 1'b1;
    set_req(1'b1, 1'b1, 3'b100, 32'h1000);
    step();
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    chk("wb_strobe", 64'(mem_writeback_o), 64'd1);
    chk("wb_addr", 64'(mem_addr_o), 64'h1000);
    chk("wb_ready_low", 64'(req_ready_o), 64'd0);
    step();
    chk("wb_strobe_drop", 64'(mem_writeback_o), 64'd0);
    chk("wb_count1", 64'(outstanding_o), 64'd1);
    do_ack(1'b0);
    chk("wb_resp", 64'(resp_valid_o), 64'd1);
    chk("wb_count0", 64'(outstanding_o), 64'd0);
    step();
    chk("wb_resp_pulse", 64'(resp_valid_o), 64'd0);

    // back-pressure: invalidate held for 5 cycles
    mem_accept_i = 1'b0;
    issue_q.push_back({3'b010, 32'h2000});
    set_req(1'b1, 1'b1, 3'b010, 32'h2000);
    step();
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {29'd0, mem_writeback_o, mem_invalidate_o, mem_flush_o, mem_addr_o},
          {29'd0, 3'b010, 32'h2000});
      chk("bp_ready", 64'(req_ready_o), 64'd0);
    end
    mem_accept_i = 1'b1;
    step();
    chk("bp_count1", 64'(outstanding_o), 64'd1);
    issue_op(3'b100, 32'h2100);
    issue_op(3'b010, 32'h2200);
    issue_op(3'b100, 32'h2300);
    chk("full_count", 64'(outstanding_o), 64'd4);
    set_req(1'b1, 1'b1, 3'b100, 32'h2400);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_blocked", {60'd0, req_ready_o, mem_writeback_o, mem_invalidate_o, mem_flush_o}, 64'd0);
    end
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    do_ack(1'b0);
    chk("full_ready_after_ack", 64'(req_ready_o), 64'd1);
    chk("full_count3", 64'(outstanding_o), 64'd3);
    do_ack(1'b0);

    // simultaneous accept and ack at count 2
    issue_q.push_back({3'b100, 32'h3000});
    set_req(1'b1, 1'b1, 3'b100, 32'h3000);
    step();
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    chk("sim_count_pre", 64'(outstanding_o), 64'd2);
    do_ack(1'b0);
    chk("sim_count", 64'(outstanding_o), 64'd2);
    chk("sim_strobe_drop", 64'(mem_writeback_o), 64'd0);

    // flush waits for both acks; accept held high is ignored in DRAIN
    issue_q.push_back({3'b001, 32'h4000});
    set_req(1'b1, 1'b1, 3'b001, 32'h4000);
    step();
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    chk("drain_flush0", 64'(mem_flush_o), 64'd0);
    chk("drain_ready", 64'(req_ready_o), 64'd0);
    step();
    chk("drain_flush0b", 64'(mem_flush_o), 64'd0);
    do_ack(1'b0);
    chk("drain_flush0c", {59'd0, mem_flush_o, outstanding_o}, 64'd1);
    do_ack(1'b0);
    chk("drain_flush0d", {59'd0, mem_flush_o, outstanding_o}, 64'd0);
    step();
    chk("drain_flush1", {31'd0, mem_flush_o, mem_addr_o}, {31'd0, 1'b1, 32'h4000});
    step();
    chk("flush_accepted", {59'd0, mem_flush_o, outstanding_o}, 64'd1);
    do_ack(1'b1);
    chk("flush_resp_err", {62'd0, resp_valid_o, resp_error_o}, 64'b11);
    chk("flush_count0", 64'(outstanding_o), 64'd0);
    chk("proto_still0", 64'(proto_err_o), 64'd0);

    // ack at count 0
    do_ack(1'b0);
    chk("proto_set", {59'd0, proto_err_o, outstanding_o}, 64'h10);
    chk("proto_resp", 64'(resp_valid_o), 64'd1);
    step(); step();
    chk("proto_sticky", 64'(proto_err_o), 64'd1);

    // invalid selects: two bits, then none
    set_req(1'b1, 1'b1, 3'b110, 32'h5555);
    step();
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    chk("sel2_err", {59'd0, sel_err_o, mem_writeback_o, mem_invalidate_o, mem_flush_o, req_ready_o}, 64'b10001);
    step();
    chk("sel2_pulse", 64'(sel_err_o), 64'd0);
    set_req(1'b1, 1'b1, 3'b000, 32'h6666);
    step();
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    chk("sel0_err", 64'(sel_err_o), 64'd1);
    step();
    chk("sel0_pulse", {61'd0, sel_err_o, mem_writeback_o, mem_flush_o}, 64'd0);

    // reset while draining a flush
    issue_op(3'b100, 32'h7000);
    set_req(1'b1, 1'b1, 3'b001, 32'h8000);
    step();
    set_req(1'b0, 1'b0, 3'b000, 32'h0);
    chk("rd_draining", {59'd0, mem_flush_o, outstanding_o}, 64'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rd_ready", 64'(req_ready_o), 64'd1);
    chk("rd_count", 64'(outstanding_o), 64'd0);
    chk("rd_addr", 64'(mem_addr_o), 64'd0);
    chk("rd_flags", {57'd0, mem_writeback_o, mem_invalidate_o, mem_flush_o,
                     resp_valid_o, resp_error_o, sel_err_o, proto_err_o}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rd_no_flush", {62'd0, mem_flush_o, req_ready_o}, 64'b01);
    end
    mem_accept_i = 1'b0;
    step();

    chk("issue_q_empty", 64'(issue_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
